// File: rtl/fb_access_arbiter.sv
// Frame-RAM arbiter: scanout reads every 4th active pixel; the clear engine or round-robin writers take the other slots.
// RAM controls are combinational, pix_color trails h_count by 2 cycles; writers hold valid until ready, stalled by scan slots and clears.
module fb_access_arbiter #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int FB_W     = 160,
   parameter int FB_H     = 120,
   parameter int COLOR_W  = 3,
   parameter int ADDR_W   = 15
) (
   input  logic               vga_clock,
   input  logic               resetn,
   input  logic [9:0]         h_count,
   input  logic [9:0]         v_count,
   input  logic               wr0_valid,
   input  logic [ADDR_W-1:0]  wr0_addr,
   input  logic [COLOR_W-1:0] wr0_data,
   output logic               wr0_ready,
   input  logic               wr1_valid,
   input  logic [ADDR_W-1:0]  wr1_addr,
   input  logic [COLOR_W-1:0] wr1_data,
   output logic               wr1_ready,
   input  logic               clear_start,
   input  logic [COLOR_W-1:0] clear_color,
   output logic               clear_busy,
   output logic               clear_done,
   output logic               wr_oob,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic               ram_we,
   output logic [COLOR_W-1:0] ram_wdata,
   input  logic [COLOR_W-1:0] ram_rdata,
   output logic [COLOR_W-1:0] pix_color
);

   localparam logic [9:0]        H_ACT   = 10'(H_ACTIVE);
   localparam logic [9:0]        V_ACT   = 10'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_W * FB_H);
   localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_W * FB_H - 1);

   typedef struct packed {
      logic               vld;
      logic [ADDR_W-1:0]  addr;
      logic [COLOR_W-1:0] dat;
   } wr_req_t;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t             state;
   logic [ADDR_W-1:0]  clear_addr;
   logic [COLOR_W-1:0] clear_color_q;
   logic               last_grant;
   logic               scan_d1;
   logic               active_d1;

   wr_req_t            req0, req1, req_sel;
   logic               active, scan_slot, wr_slot;
   logic               clear_wr, grant0, grant1, granted, sel_oob;
   logic [ADDR_W-1:0]  v_fb, h_fb, scan_addr;

   assign req0 = {wr0_valid, wr0_addr, wr0_data};
   assign req1 = {wr1_valid, wr1_addr, wr1_data};

   assign active    = (h_count < H_ACT) && (v_count < V_ACT);
   assign scan_slot = active && (h_count[1:0] == 2'b00);
   assign wr_slot   = !scan_slot;

   // Row offset of 160 built as 128 + 32 to avoid a multiplier.
   assign v_fb      = ADDR_W'(v_count[9:2]);
   assign h_fb      = ADDR_W'(h_count[9:2]);
   assign scan_addr = (v_fb << 7) + (v_fb << 5) + h_fb;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!resetn && wr_slot && state == IDLE) begin
         grant0 = req0.vld && (!req1.vld || last_grant);
         grant1 = req1.vld && (!req0.vld || !last_grant);
      end
      req_sel  = grant1 ? req1 : req0;
      granted  = (grant0 || grant1) && req_sel.vld;
      sel_oob  = req_sel.addr >= FB_SIZE;
      clear_wr = !resetn && wr_slot && state == CLEAR;
   end

   assign wr0_ready = grant0;
   assign wr1_ready = grant1;

   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      if (scan_slot) begin
         ram_addr = scan_addr;
      end else if (clear_wr) begin
         ram_addr  = clear_addr;
         ram_we    = 1'b1;
         ram_wdata = clear_color_q;
      end else if (granted) begin
         // Out-of-range writes complete the handshake but never reach the RAM.
         ram_addr  = req_sel.addr;
         ram_we    = !sel_oob;
         ram_wdata = req_sel.dat;
      end
   end

   always_ff @(posedge vga_clock) begin
      if (resetn) begin
         state         <= IDLE;
         clear_addr    <= '0;
         clear_color_q <= '0;
         clear_busy    <= 1'b0;
         clear_done    <= 1'b0;
         wr_oob        <= 1'b0;
         last_grant    <= 1'b1;
         scan_d1       <= 1'b0;
         active_d1     <= 1'b0;
         pix_color     <= '0;
      end else begin
         scan_d1    <= scan_slot;
         active_d1  <= active;
         clear_done <= 1'b0;

         if (!active_d1)
            pix_color <= '0;
         else if (scan_d1)
            pix_color <= ram_rdata;

         if (granted) begin
            last_grant <= grant1;
            if (sel_oob)
               wr_oob <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (clear_start) begin
                  state         <= CLEAR;
                  clear_color_q <= clear_color;
                  clear_addr    <= '0;
                  clear_busy    <= 1'b1;
               end
            end
            CLEAR: begin
               if (clear_wr) begin
                  if (clear_addr == FB_LAST) begin
                     state      <= IDLE;
                     clear_addr <= '0;
                     clear_busy <= 1'b0;
                     clear_done <= 1'b1;
                  end else begin
                     clear_addr <= clear_addr + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a behavioural 1-cycle-latency frame RAM.
module tb_fb_access_arbiter;

   localparam int ADDR_W  = 15;
   localparam int COLOR_W = 3;

   logic               vga_clock = 1'b0;
   logic               resetn;
   logic [9:0]         h_count, v_count;
   logic               wr0_valid, wr1_valid;
   logic [ADDR_W-1:0]  wr0_addr, wr1_addr;
   logic [COLOR_W-1:0] wr0_data, wr1_data;
   logic               wr0_ready, wr1_ready;
   logic               clear_start;
   logic [COLOR_W-1:0] clear_color;
   logic               clear_busy, clear_done, wr_oob;
   logic [ADDR_W-1:0]  ram_addr;
   logic               ram_we;
   logic [COLOR_W-1:0] ram_wdata;
   logic [COLOR_W-1:0] ram_rdata = '0;
   logic [COLOR_W-1:0] pix_color;

   logic [COLOR_W-1:0] mem [0:32767];

   int total = 0;
   int bad   = 0;
   int h = 0;
   int v = 0;

   always #5 vga_clock = ~vga_clock;

   always @(posedge vga_clock) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   fb_access_arbiter dut (
      .vga_clock   (vga_clock),
      .resetn      (resetn),
      .h_count     (h_count),
      .v_count     (v_count),
      .wr0_valid   (wr0_valid),
      .wr0_addr    (wr0_addr),
      .wr0_data    (wr0_data),
      .wr0_ready   (wr0_ready),
      .wr1_valid   (wr1_valid),
      .wr1_addr    (wr1_addr),
      .wr1_data    (wr1_data),
      .wr1_ready   (wr1_ready),
      .clear_start (clear_start),
      .clear_color (clear_color),
      .clear_busy  (clear_busy),
      .clear_done  (clear_done),
      .wr_oob      (wr_oob),
      .ram_addr    (ram_addr),
      .ram_we      (ram_we),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata),
      .pix_color   (pix_color)
   );

   task automatic tick();
      @(posedge vga_clock);
      #1;
   endtask

   task automatic set_hv(input int hh, input int vv);
      h = hh;
      v = vv;
      h_count = 10'(h);
      v_count = 10'(v);
   endtask

   task automatic adv();
      h++;
      if (h == 800) begin
         h = 0;
         v++;
         if (v == 525) v = 0;
      end
      h_count = 10'(h);
      v_count = 10'(v);
   endtask

   function automatic bit is_scan();
      return (h < 640) && (v < 480) && (h % 4 == 0);
   endfunction

   task automatic test_reset();
      resetn = 1'b1;
      set_hv(799, 524);
      wr0_valid = 1'b1; wr0_addr = 15'd5; wr0_data = 3'd1;
      repeat (3) tick();
      #1;
      total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", clear_busy); end
      total++; if (clear_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", clear_done); end
      total++; if (wr_oob !== 1'b0) begin bad++; $display("FAIL reset_oob: got %b want 0", wr_oob); end
      total++; if (pix_color !== 3'd0) begin bad++; $display("FAIL reset_pix: got %0d want 0", pix_color); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", ram_we); end
      total++; if (wr0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", wr0_ready); end
      wr0_valid = 1'b0;
      tick();
      resetn = 1'b0;
   endtask

   task automatic test_scanout();
      logic [2:0] exp_pix;
      for (int k = 0; k < 12; k++) begin
         tick();
         set_hv(k, 0);
         #1;
         if (k % 4 == 0) begin
            total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL scan_we h=%0d: got %b want 0", k, ram_we); end
            total++; if (ram_addr !== 15'(k / 4)) begin bad++; $display("FAIL scan_addr h=%0d: got %0d want %0d", k, ram_addr, k / 4); end
         end
         if (k <= 9) begin
            exp_pix = (k < 2) ? 3'd0 : (k < 6) ? 3'd5 : 3'd3;
            total++; if (pix_color !== exp_pix) begin bad++; $display("FAIL scan_pix cycle=%0d: got %0d want %0d", k, pix_color, exp_pix); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic e0;
      for (int i = 0; i < 6; i++) begin
         tick();
         set_hv(700, 0);
         wr0_valid = 1'b1; wr0_addr = 15'd100; wr0_data = 3'd1;
         wr1_valid = 1'b1; wr1_addr = 15'd200; wr1_data = 3'd6;
         #1;
         e0 = (i % 2 == 0);
         total++; if (wr0_ready !== e0) begin bad++; $display("FAIL rr_ready0 i=%0d: got %b want %b", i, wr0_ready, e0); end
         total++; if (wr1_ready !== !e0) begin bad++; $display("FAIL rr_ready1 i=%0d: got %b want %b", i, wr1_ready, !e0); end
         total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL rr_we i=%0d: got %b want 1", i, ram_we); end
         total++; if (ram_addr !== (e0 ? 15'd100 : 15'd200)) begin bad++; $display("FAIL rr_addr i=%0d: got %0d want %0d", i, ram_addr, e0 ? 100 : 200); end
         total++; if (ram_wdata !== (e0 ? 3'd1 : 3'd6)) begin bad++; $display("FAIL rr_data i=%0d: got %0d want %0d", i, ram_wdata, e0 ? 1 : 6); end
      end
      tick();
      wr0_valid = 1'b0; wr1_valid = 1'b0;
   endtask

   task automatic test_active_write();
      logic er;
      for (int k = 0; k < 8; k++) begin
         tick();
         set_hv(k, 10);
         wr0_valid = 1'b1; wr0_addr = 15'd300; wr0_data = 3'd4;
         #1;
         er = (k % 4 != 0);
         total++; if (wr0_ready !== er) begin bad++; $display("FAIL act_ready h=%0d: got %b want %b", k, wr0_ready, er); end
         total++; if (ram_we !== er) begin bad++; $display("FAIL act_we h=%0d: got %b want %b", k, ram_we, er); end
         if (!er) begin
            total++; if (ram_addr !== 15'(320 + k / 4)) begin bad++; $display("FAIL act_scan_addr h=%0d: got %0d want %0d", k, ram_addr, 320 + k / 4); end
         end
      end
      tick();
      wr0_valid = 1'b0;
   endtask

   task automatic test_oob();
      tick();
      set_hv(700, 0);
      wr1_valid = 1'b1; wr1_addr = 15'd19200; wr1_data = 3'd7;
      #1;
      total++; if (wr1_ready !== 1'b1) begin bad++; $display("FAIL oob_ready: got %b want 1", wr1_ready); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL oob_we: got %b want 0", ram_we); end
      total++; if (wr_oob !== 1'b0) begin bad++; $display("FAIL oob_early: got %b want 0", wr_oob); end
      tick();
      wr0_valid = 1'b1; wr0_addr = 15'd19199; wr0_data = 3'd2;
      wr1_valid = 1'b1; wr1_addr = 15'd50;    wr1_data = 3'd3;
      #1;
      total++; if (wr_oob !== 1'b1) begin bad++; $display("FAIL oob_set: got %b want 1", wr_oob); end
      total++; if (wr0_ready !== 1'b1) begin bad++; $display("FAIL oob_lastgrant: got %b want 1", wr0_ready); end
      total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL edge_we: got %b want 1", ram_we); end
      total++; if (ram_addr !== 15'd19199) begin bad++; $display("FAIL edge_addr: got %0d want 19199", ram_addr); end
      tick();
      wr0_valid = 1'b0; wr1_valid = 1'b0;
      repeat (5) tick();
      total++; if (wr_oob !== 1'b1) begin bad++; $display("FAIL oob_sticky: got %b want 1", wr_oob); end
   endtask

   task automatic test_clear();
      int nwr = 0;
      int ndone = 0;
      bit fin = 0;
      tick();
      set_hv(0, 0);
      clear_start = 1'b1; clear_color = 3'd2;
      wr0_valid = 1'b1; wr0_addr = 15'd10; wr0_data = 3'd5;
      for (int c = 0; c < 30000 && !fin; c++) begin
         tick();
         adv();
         clear_start = (nwr == 100);
         clear_color = (nwr == 100) ? 3'd7 : 3'd2;
         #1;
         if (c == 0) begin
            total++; if (clear_busy !== 1'b1) begin bad++; $display("FAIL clr_busy: got %b want 1", clear_busy); end
         end
         if (clear_done === 1'b1) begin
            ndone++;
            fin = 1;
         end else if (clear_busy === 1'b1) begin
            total++; if (wr0_ready !== 1'b0) begin bad++; if (bad < 10) $display("FAIL clr_wr0_ready n=%0d: got %b want 0", nwr, wr0_ready); end
            total++; if (ram_we !== !is_scan()) begin bad++; if (bad < 10) $display("FAIL clr_slot h=%0d v=%0d: got %b want %b", h, v, ram_we, !is_scan()); end
            if (ram_we === 1'b1) begin
               total++; if (ram_addr !== 15'(nwr)) begin bad++; if (bad < 10) $display("FAIL clr_addr: got %0d want %0d", ram_addr, nwr); end
               total++; if (ram_wdata !== 3'd2) begin bad++; if (bad < 10) $display("FAIL clr_data n=%0d: got %0d want 2", nwr, ram_wdata); end
               nwr++;
            end
         end
      end
      clear_start = 1'b0;
      wr0_valid = 1'b0;
      total++; if (nwr != 19200) begin bad++; $display("FAIL clr_count: got %0d want 19200", nwr); end
      total++; if (ndone != 1) begin bad++; $display("FAIL clr_done_seen: got %0d want 1", ndone); end
      for (int c = 0; c < 5; c++) begin
         tick();
         adv();
         #1;
         total++; if (clear_done !== 1'b0) begin bad++; $display("FAIL clr_done_pulse c=%0d: got %b want 0", c, clear_done); end
      end
      total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL clr_idle: got %b want 0", clear_busy); end
   endtask

   task automatic test_reset_mid_clear();
      bit hit = 0;
      tick();
      adv();
      clear_start = 1'b1; clear_color = 3'd6;
      for (int c = 0; c < 20000 && !hit; c++) begin
         tick();
         adv();
         clear_start = 1'b0;
         #1;
         if (ram_we === 1'b1 && ram_addr === 15'd5000) begin
            hit = 1;
            resetn = 1'b1;
         end
      end
      total++; if (!hit) begin bad++; $display("FAIL mid_reach: got no write to 5000 want one"); end
      #1;
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL mid_we_in_reset: got %b want 0", ram_we); end
      tick();
      adv();
      #1;
      total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", clear_busy); end
      total++; if (pix_color !== 3'd0) begin bad++; $display("FAIL mid_pix: got %0d want 0", pix_color); end
      total++; if (wr_oob !== 1'b0) begin bad++; $display("FAIL mid_oob: got %b want 0", wr_oob); end
      resetn = 1'b0;
      for (int c = 0; c < 50; c++) begin
         tick();
         adv();
         #1;
         total++; if (clear_done !== 1'b0 || clear_busy !== 1'b0) begin bad++; $display("FAIL mid_resume c=%0d: got done=%b busy=%b want 0 0", c, clear_done, clear_busy); end
         total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL mid_we c=%0d: got %b want 0", c, ram_we); end
      end
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = '0;
      mem[0] = 3'b101;
      mem[1] = 3'b011;
      resetn = 1'b1;
      set_hv(799, 524);
      wr0_valid = 1'b0; wr0_addr = '0; wr0_data = '0;
      wr1_valid = 1'b0; wr1_addr = '0; wr1_data = '0;
      clear_start = 1'b0; clear_color = '0;

      test_reset();
      test_scanout();
      test_back_to_back();
      test_active_write();
      test_oob();
      test_clear();
      test_reset_mid_clear();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
